// File: rtl/usb_line_pkg.sv
// Shared definitions for the USB transmit line stage.
// - Line-level encodings {D+, D-} for J, K and SE0 at full and low speed.
// - PID constants used by the upstream handshake generators.
// - Transmit FSM state enum and the default bit-stuffing limit.
package usb_line_pkg;

  // {dPlus, dMinus}
  localparam logic [1:0] LineJFs = 2'b10;
  localparam logic [1:0] LineKFs = 2'b01;
  localparam logic [1:0] LineJLs = 2'b01;
  localparam logic [1:0] LineKLs = 2'b10;
  localparam logic [1:0] LineSe0 = 2'b00;

  localparam logic [7:0] PidNak = 8'h5A;
  localparam logic [7:0] PidAck = 8'hD2;

  localparam int unsigned StuffLimitDefault = 6;

  typedef enum logic [1:0] {
    StIdle,
    StData,
    StEopSe0,
    StEopJ
  } tx_state_e;

  function automatic logic [1:0] line_j(logic low_speed);
    return low_speed ? LineJLs : LineJFs;
  endfunction

  function automatic logic [1:0] line_k(logic low_speed);
    return low_speed ? LineKLs : LineKFs;
  endfunction

endpackage

// File: rtl/usb_nrzi_stuffer.sv
// NRZI line-level register plus consecutive-ones counter for bit stuffing.
// Ports:
//   clk_i, rst_ni  clock and asynchronous active-low reset
//   strobe_i       bit-time strobe; nothing changes without it
//   start_i        encode bit_i starting from J (first bit of a packet)
//   enc_i          encode bit_i from the current level
//   stuff_i        insert a stuffed 0 (toggle) and clear the ones run
//   bit_i          raw bit to encode
//   level_j_o      1 = line at J, 0 = line at K
//   stuff_due_o    ones run has reached the stuffing limit
module usb_nrzi_stuffer #(
  parameter int unsigned StuffLimit = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic strobe_i,
  input  logic start_i,
  input  logic enc_i,
  input  logic stuff_i,
  input  logic bit_i,
  output logic level_j_o,
  output logic stuff_due_o
);

  localparam int unsigned CntW = $clog2(StuffLimit + 1);

  logic            level_q, level_d;
  logic [CntW-1:0] ones_q, ones_d;

  assign stuff_due_o = (ones_q == CntW'(StuffLimit));
  assign level_j_o   = level_q;

  always_comb begin
    level_d = level_q;
    ones_d  = ones_q;
    if (strobe_i) begin
      if (start_i) begin
        // From J: a 1 holds J, a 0 toggles to K.
        level_d = bit_i;
        ones_d  = bit_i ? CntW'(1) : '0;
      end else if (stuff_i) begin
        level_d = ~level_q;
        ones_d  = '0;
      end else if (enc_i) begin
        level_d = bit_i ? level_q : ~level_q;
        if (!bit_i) begin
          ones_d = '0;
        end else if (!stuff_due_o) begin
          ones_d = ones_q + 1'b1;
        end
      end else begin
        // Outside a packet the level parks at J with no partial run.
        level_d = 1'b1;
        ones_d  = '0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      level_q <= 1'b1;
      ones_q  <= '0;
    end else begin
      level_q <= level_d;
      ones_q  <= ones_d;
    end
  end

endmodule

// File: rtl/usb_tx_line_driver.sv
// USB transmit line stage: NRZI encoding, bit stuffing and EOP generation.
// Ports:
//   useClk, nReset  clock and asynchronous active-low reset
//   checkData       one-cycle bit-time strobe shared with upstream generators
//   txBit           raw LSB-first bit from upstream
//   txOE            upstream packet-active flag
//   callEop         upstream EOP request (edge-armed, one EOP per assertion)
//   stuffStall      upstream must not advance while high
//   dPlus, dMinus   line levels toward the pads
//   oeLine          pad output enable
//   txBusy          FSM is outside IDLE
module usb_tx_line_driver
  import usb_line_pkg::*;
#(
  parameter int unsigned LOW_SPEED    = 0,
  parameter int unsigned STUFF_LIMIT  = StuffLimitDefault,
  parameter int unsigned EOP_SE0_BITS = 2
) (
  input  logic useClk,
  input  logic nReset,
  input  logic checkData,
  input  logic txBit,
  input  logic txOE,
  input  logic callEop,
  output logic stuffStall,
  output logic dPlus,
  output logic dMinus,
  output logic oeLine,
  output logic txBusy
);

  localparam int unsigned EopW = $clog2(EOP_SE0_BITS + 1);
  localparam logic [1:0]  JLvl = line_j(LOW_SPEED != 0);
  localparam logic [1:0]  KLvl = line_k(LOW_SPEED != 0);

  tx_state_e       state_q, state_d;
  logic [EopW-1:0] eop_cnt_q, eop_cnt_d;
  logic            eop_seen_q, eop_seen_d;

  logic start, enc, stuff;
  logic level_j, stuff_due;
  logic [1:0] line_lvl;

  usb_nrzi_stuffer #(
    .StuffLimit (STUFF_LIMIT)
  ) u_nrzi_stuffer (
    .clk_i       (useClk),
    .rst_ni      (nReset),
    .strobe_i    (checkData),
    .start_i     (start),
    .enc_i       (enc),
    .stuff_i     (stuff),
    .bit_i       (txBit),
    .level_j_o   (level_j),
    .stuff_due_o (stuff_due)
  );

  assign stuffStall = (state_q == StData) && stuff_due;
  assign txBusy     = (state_q != StIdle);

  always_comb begin
    state_d    = state_q;
    eop_cnt_d  = eop_cnt_q;
    eop_seen_d = eop_seen_q;
    start      = 1'b0;
    enc        = 1'b0;
    stuff      = 1'b0;
    if (checkData) begin
      if (!callEop) begin
        eop_seen_d = 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          // A stale callEop must not open a packet.
          if (txOE && !callEop) begin
            start   = 1'b1;
            state_d = StData;
          end
        end
        StData: begin
          if (callEop && !eop_seen_q) begin
            state_d    = StEopSe0;
            eop_cnt_d  = EopW'(1);
            eop_seen_d = 1'b1;
          end else if (!txOE) begin
            state_d = StIdle;
          end else if (stuff_due) begin
            // txBit stays unconsumed; upstream is held by stuffStall.
            stuff = 1'b1;
          end else begin
            enc = 1'b1;
          end
        end
        StEopSe0: begin
          if (eop_cnt_q == EopW'(EOP_SE0_BITS)) begin
            state_d = StEopJ;
          end else begin
            eop_cnt_d = eop_cnt_q + 1'b1;
          end
        end
        StEopJ: begin
          state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  // Line outputs decode from registered state only, so reset drives J/oe=0 at once.
  always_comb begin
    line_lvl = JLvl;
    oeLine   = 1'b0;
    unique case (state_q)
      StIdle: begin
        line_lvl = JLvl;
        oeLine   = 1'b0;
      end
      StData: begin
        line_lvl = level_j ? JLvl : KLvl;
        oeLine   = 1'b1;
      end
      StEopSe0: begin
        line_lvl = LineSe0;
        oeLine   = 1'b1;
      end
      StEopJ: begin
        line_lvl = JLvl;
        oeLine   = 1'b1;
      end
      default: begin
        line_lvl = JLvl;
        oeLine   = 1'b0;
      end
    endcase
  end

  assign dPlus  = line_lvl[1];
  assign dMinus = line_lvl[0];

  always_ff @(posedge useClk or negedge nReset) begin
    if (!nReset) begin
      state_q    <= StIdle;
      eop_cnt_q  <= '0;
      eop_seen_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      eop_cnt_q  <= eop_cnt_d;
      eop_seen_q <= eop_seen_d;
    end
  end

endmodule

// File: tb/tb_usb_tx_line_driver.sv
// Scoreboard bench for usb_tx_line_driver: a full-speed and a low-speed instance
// share stimulus; each strobe pushes the expected line symbol, and a monitor
// compares both instances one step after every strobed clock edge.
module tb_usb_tx_line_driver;

  localparam logic [1:0] SJ = 2'd0;
  localparam logic [1:0] SK = 2'd1;
  localparam logic [1:0] SS = 2'd2;

  typedef struct packed {
    logic [1:0] sym;
    logic       oe;
    logic       stall;
  } exp_t;

  logic useClk = 1'b0;
  logic nReset = 1'b0;
  logic checkData = 1'b0;
  logic txBit = 1'b0;
  logic txOE = 1'b0;
  logic callEop = 1'b0;

  logic stall_fs, dp_fs, dm_fs, oe_fs, busy_fs;
  logic stall_ls, dp_ls, dm_ls, oe_ls, busy_ls;

  int    checks = 0;
  int    failures = 0;
  int    strobe_idx = 0;
  string test_name = "reset";
  exp_t  exp_q[$];

  bit nak_bits [14] = '{0, 0, 0, 0, 0, 1, 0, 1, 0, 1, 1, 0, 1, 0};
  bit nak_k    [14] = '{1, 0, 1, 0, 1, 1, 0, 0, 1, 1, 1, 0, 0, 1};

  always #5 useClk = ~useClk;

  usb_tx_line_driver #(
    .LOW_SPEED    (0),
    .STUFF_LIMIT  (6),
    .EOP_SE0_BITS (2)
  ) dut_fs (
    .useClk     (useClk),
    .nReset     (nReset),
    .checkData  (checkData),
    .txBit      (txBit),
    .txOE       (txOE),
    .callEop    (callEop),
    .stuffStall (stall_fs),
    .dPlus      (dp_fs),
    .dMinus     (dm_fs),
    .oeLine     (oe_fs),
    .txBusy     (busy_fs)
  );

  usb_tx_line_driver #(
    .LOW_SPEED    (1),
    .STUFF_LIMIT  (6),
    .EOP_SE0_BITS (2)
  ) dut_ls (
    .useClk     (useClk),
    .nReset     (nReset),
    .checkData  (checkData),
    .txBit      (txBit),
    .txOE       (txOE),
    .callEop    (callEop),
    .stuffStall (stall_ls),
    .dPlus      (dp_ls),
    .dMinus     (dm_ls),
    .oeLine     (oe_ls),
    .txBusy     (busy_ls)
  );

  // {dPlus, dMinus} for a symbol at the given speed.
  function automatic logic [1:0] lines(logic [1:0] s, bit ls);
    case (s)
      SJ:      return ls ? 2'b01 : 2'b10;
      SK:      return ls ? 2'b10 : 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  // {dPlus, dMinus, oeLine, stuffStall, txBusy}; busy tracks oe in every state.
  function automatic logic [4:0] want_vec(exp_t e, bit ls);
    return {lines(e.sym, ls), e.oe, e.stall, e.oe};
  endfunction

  task automatic check(input string name, input logic [4:0] got, input logic [4:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s strobe=%0d got{dp,dm,oe,stall,busy}=%b want=%b",
               name, strobe_idx, got, want);
    end
  endtask

  task automatic check_both(input string tag, input exp_t e);
    check({test_name, "/", tag, "/fs"}, {dp_fs, dm_fs, oe_fs, stall_fs, busy_fs},
          want_vec(e, 1'b0));
    check({test_name, "/", tag, "/ls"}, {dp_ls, dm_ls, oe_ls, stall_ls, busy_ls},
          want_vec(e, 1'b1));
  endtask

  task automatic strobe(input logic b, input logic oe, input logic eop,
                        input logic [1:0] s, input logic e_oe, input logic e_st);
    exp_t e;
    @(negedge useClk);
    txBit     = b;
    txOE      = oe;
    callEop   = eop;
    checkData = 1'b1;
    e.sym     = s;
    e.oe      = e_oe;
    e.stall   = e_st;
    exp_q.push_back(e);
  endtask

  task automatic gap(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge useClk);
      checkData = 1'b0;
      txBit     = 1'($urandom_range(0, 1));
    end
  endtask

  // Monitor: one expected entry per strobed clock edge.
  initial begin
    logic st;
    exp_t e;
    forever begin
      @(posedge useClk);
      st = checkData;
      #1;
      if (st) begin
        strobe_idx++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL %s strobe=%0d got=strobe want=no_strobe (empty queue)",
                   test_name, strobe_idx);
        end else begin
          e = exp_q.pop_front();
          check_both("line", e);
        end
      end
    end
  end

  initial begin
    exp_t idle_e;
    exp_t k_stall_e;
    int   wait_cyc;
    idle_e    = '{sym: SJ, oe: 1'b0, stall: 1'b0};
    k_stall_e = '{sym: SK, oe: 1'b1, stall: 1'b1};

    #1;
    check_both("reset_idle", idle_e);
    repeat (3) @(negedge useClk);
    nReset = 1'b1;

    // NAK: sync tail plus PID, then EOP; txOE held high through EOP is ignored.
    test_name = "nak";
    for (int i = 0; i < 14; i++) begin
      strobe(nak_bits[i], 1'b1, 1'b0, nak_k[i] ? SK : SJ, 1'b1, 1'b0);
    end
    strobe(1'b0, 1'b1, 1'b1, SS, 1'b1, 1'b0);
    strobe(1'b0, 1'b1, 1'b0, SS, 1'b1, 1'b0);
    strobe(1'b0, 1'b1, 1'b0, SJ, 1'b1, 1'b0);
    strobe(1'b0, 1'b1, 1'b0, SJ, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, SJ, 1'b0, 1'b0);
    gap(2);

    // Stuffing: 0 then eight 1s, with a frozen gap while the stall is pending.
    test_name = "stuff";
    strobe(1'b0, 1'b1, 1'b0, SK, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1, 1'b0, SK, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0, SK, 1'b1, 1'b1);
    gap(3);
    check_both("freeze", k_stall_e);
    strobe(1'b1, 1'b1, 1'b0, SJ, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0, SJ, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0, SJ, 1'b1, 1'b0);
    strobe(1'b0, 1'b1, 1'b1, SS, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, SS, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, SJ, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, SJ, 1'b0, 1'b0);

    // Abort mid-packet, then a fresh packet must count its ones from zero.
    test_name = "abort";
    strobe(1'b0, 1'b1, 1'b0, SK, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0, SK, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0, SK, 1'b1, 1'b0);
    strobe(1'b1, 1'b0, 1'b0, SJ, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) strobe(1'b1, 1'b1, 1'b0, SJ, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0, SJ, 1'b1, 1'b1);
    strobe(1'b1, 1'b0, 1'b0, SJ, 1'b0, 1'b0);
    // Stale callEop in IDLE does not open a packet.
    strobe(1'b0, 1'b1, 1'b1, SJ, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, SJ, 1'b0, 1'b0);
    gap(1);

    // callEop held for three strobes gives exactly two SE0 and one J.
    test_name = "eophold";
    strobe(1'b0, 1'b1, 1'b0, SK, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0, SK, 1'b1, 1'b0);
    strobe(1'b0, 1'b1, 1'b1, SS, 1'b1, 1'b0);
    strobe(1'b0, 1'b1, 1'b1, SS, 1'b1, 1'b0);
    strobe(1'b0, 1'b1, 1'b1, SJ, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, SJ, 1'b0, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, SJ, 1'b0, 1'b0);

    // Asynchronous reset during EOP_SE0, checked between clock edges.
    test_name = "reset_eop";
    strobe(1'b0, 1'b1, 1'b0, SK, 1'b1, 1'b0);
    strobe(1'b0, 1'b1, 1'b1, SS, 1'b1, 1'b0);
    @(negedge useClk);
    checkData = 1'b0;
    callEop   = 1'b0;
    txOE      = 1'b0;
    #2;
    nReset = 1'b0;
    #1;
    check_both("async", idle_e);
    @(negedge useClk);
    nReset = 1'b1;
    strobe(1'b0, 1'b1, 1'b0, SK, 1'b1, 1'b0);
    strobe(1'b1, 1'b1, 1'b0, SK, 1'b1, 1'b0);
    strobe(1'b0, 1'b0, 1'b0, SJ, 1'b0, 1'b0);
    gap(2);

    wait_cyc = 0;
    while (exp_q.size() != 0 && wait_cyc < 20) begin
      @(negedge useClk);
      wait_cyc++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
